pipe_hazard_ctl: RTL and testbench

Pipeline sequencing controller for the five-stage core. It sits beside the decode stage and produces the write-enables and bubble/flush strobes for the PC and all four pipeline registers. It resolves load-use and decode-resolved branch/jump operand hazards, redirect flushes, data-memory wait states and halt draining. It also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_hazard_ctl_if.sv | 69 ++++++
 rtl/pipe_hazard_ctl.sv | 186 ++++++++++++++++++
 tb/tb_pipe_hazard_ctl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctl_if
//   Bundles every signal exchanged between the pipeline sequencing
//   controller and the five-stage core.
//
//   Core -> controller (decode-stage view of the pipe):
//     id_rs, id_rt           source register selects of the ID instruction
//     id_rs_used, id_rt_used ID instruction actually reads that source
//     id_ctl                 ID instruction resolves in decode, reads id_rs
//     id_halt                ID instruction is HALT
//     ex_rd/ex_regwrite/ex_memread     ID/EX occupant destination fields
//     mem_rd/mem_regwrite/mem_memread  EX/MEM occupant destination fields
//     pcsrc                  decode redirect this cycle
//     imem_stall             instruction fetch not ready
//     dmem_busy, dmem_done   data-memory wait and completion pulse
//
//   Controller -> core:
//     pc_we, ifid_we, exmem_we        load/advance enables
//     ifid_flush, idex_bubble, memwb_bubble  NOP-insert strobes
//     halted                 core has drained and stopped (registered)
//     stall_cnt              saturating stall-cycle counter (registered)
//
//   Modports: master = core side, slave = controller side.
// ---------------------------------------------------------------------------
interface pipe_hazard_ctl_if;
    logic [2:0]  id_rs;
    logic [2:0]  id_rt;
    logic        id_rs_used;
    logic        id_rt_used;
    logic        id_ctl;
    logic        id_halt;
    logic [2:0]  ex_rd;
    logic        ex_regwrite;
    logic        ex_memread;
    logic [2:0]  mem_rd;
    logic        mem_regwrite;
    logic        mem_memread;
    logic        pcsrc;
    logic        imem_stall;
    logic        dmem_busy;
    logic        dmem_done;

    logic        pc_we;
    logic        ifid_we;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        exmem_we;
    logic        memwb_bubble;
    logic        halted;
    logic [15:0] stall_cnt;

    modport master (
        output id_rs, id_rt, id_rs_used, id_rt_used, id_ctl, id_halt,
               ex_rd, ex_regwrite, ex_memread,
               mem_rd, mem_regwrite, mem_memread,
               pcsrc, imem_stall, dmem_busy, dmem_done,
        input  pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we,
               memwb_bubble, halted, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_rs_used, id_rt_used, id_ctl, id_halt,
               ex_rd, ex_regwrite, ex_memread,
               mem_rd, mem_regwrite, mem_memread,
               pcsrc, imem_stall, dmem_busy, dmem_done,
        output pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we,
               memwb_bubble, halted, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctl
//   Pipeline sequencing controller for the five-stage core. Sits beside
//   decode and produces the PC / pipeline-register enables and the
//   bubble/flush strobes. Resolves load-use and decode-resolved branch
//   operand hazards, redirect flushes, data-memory wait states and halt
//   draining, and keeps a saturating stall-cycle counter.
//
//   Ports:
//     clk  core clock, rising edge
//     rst  asynchronous reset, active-low
//     bus  pipe_hazard_ctl_if.slave (all hazard inputs and strobes)
//
//   All strobes are Mealy outputs of the state plus current inputs.
//   While rst is low the strobes are forced to a safe "hold everything,
//   insert NOPs" pattern.
// ---------------------------------------------------------------------------
module pipe_hazard_ctl (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_MWAIT = 2'd1,
        S_DRAIN = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  dcnt_q, dcnt_d;
    logic        halted_q, halted_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic        lu, cx, cm, hz;
    logic        run_eval;
    logic        busy_eff;

    logic        pc_we;
    logic        ifid_we;
    logic        exmem_we;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        memwb_bubble;

    // Hazard terms. R0 is an ordinary register: no zero exemption.
    assign lu = bus.ex_memread & bus.ex_regwrite &
                ((bus.id_rs_used & (bus.ex_rd == bus.id_rs)) |
                 (bus.id_rt_used & (bus.ex_rd == bus.id_rt)));
    assign cx = bus.id_ctl & bus.ex_regwrite & (bus.ex_rd == bus.id_rs);
    assign cm = bus.id_ctl & bus.mem_memread & bus.mem_regwrite &
                (bus.mem_rd == bus.id_rs);
    assign hz = lu | cx | cm;

    always_comb begin
        state_d      = state_q;
        dcnt_d       = dcnt_q;
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        exmem_we     = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        memwb_bubble = 1'b0;
        run_eval     = 1'b0;
        busy_eff     = bus.dmem_busy;

        case (state_q)
            S_RUN: begin
                run_eval = 1'b1;
            end

            S_MWAIT: begin
                // The completing cycle behaves like RUN with the busy
                // flag ignored, so the held ID instruction issues at once.
                if (bus.dmem_done) begin
                    run_eval = 1'b1;
                    busy_eff = 1'b0;
                end else begin
                    pc_we    = 1'b0;
                    ifid_we  = 1'b0;
                    exmem_we = 1'b0;
                end
            end

            S_DRAIN: begin
                if (bus.dmem_busy) begin
                    // Frozen: the drain counter waits with the pipe.
                    pc_we    = 1'b0;
                    ifid_we  = 1'b0;
                    exmem_we = 1'b0;
                end else begin
                    pc_we      = 1'b0;
                    ifid_flush = 1'b1;
                    if (dcnt_q == 2'd0) begin
                        state_d = S_HALT;
                    end else begin
                        dcnt_d = dcnt_q - 2'd1;
                    end
                end
            end

            S_HALT: begin
                pc_we        = 1'b0;
                ifid_we      = 1'b0;
                exmem_we     = 1'b0;
                memwb_bubble = 1'b1;
            end

            default: begin
                state_d = S_RUN;
            end
        endcase

        if (run_eval) begin
            state_d = S_RUN;
            if (busy_eff) begin
                // Whole-pipe freeze; a concurrent redirect stays latched
                // in the frozen ID and is taken after the wait.
                state_d  = S_MWAIT;
                pc_we    = 1'b0;
                ifid_we  = 1'b0;
                exmem_we = 1'b0;
            end else if (hz) begin
                // Stall beats redirect: the branch operand is not ready.
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_bubble = 1'b1;
            end else if (bus.pcsrc) begin
                ifid_flush = 1'b1;
            end else if (bus.imem_stall) begin
                pc_we      = 1'b0;
                ifid_flush = 1'b1;
            end else if (bus.id_halt) begin
                // HALT moves on toward WB; fetch stops behind it.
                pc_we      = 1'b0;
                ifid_flush = 1'b1;
                state_d    = S_DRAIN;
                dcnt_d     = 2'd2;
            end
        end

        if (!rst) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            exmem_we     = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            memwb_bubble = 1'b1;
        end
    end

    assign halted_d = (state_d == S_HALT);

    // Counts fetch-blocked cycles outside HALT, saturating at all ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_we && (state_q != S_HALT) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_RUN;
            dcnt_q      <= 2'd0;
            halted_q    <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            halted_q    <= halted_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.pc_we        = pc_we;
    assign bus.ifid_we      = ifid_we;
    assign bus.exmem_we     = exmem_we;
    assign bus.ifid_flush   = ifid_flush;
    assign bus.idex_bubble  = idex_bubble;
    assign bus.memwb_bubble = memwb_bubble;
    assign bus.halted       = halted_q;
    assign bus.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
module tb_pipe_hazard_ctl;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    pipe_hazard_ctl_if bus ();

    pipe_hazard_ctl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: plain facts about the core, not an FSM encoding.
    bit m_stopped;      // core has halted
    bit m_waiting;      // a data access is holding the pipe
    int m_drain_left;   // -1: no halt in flight, else drain steps remaining
    int m_stalls;       // fetch-blocked cycles, saturating

    // Strobe vector order: pc_we, ifid_we, exmem_we, ifid_flush, idex_bubble, memwb_bubble
    localparam logic [5:0] O_RESET  = 6'b000111;
    localparam logic [5:0] O_FREEZE = 6'b000000;
    localparam logic [5:0] O_HALT   = 6'b000001;
    localparam logic [5:0] O_FETCHX = 6'b011100;
    localparam logic [5:0] O_BUBBLE = 6'b001010;
    localparam logic [5:0] O_REDIR  = 6'b111100;
    localparam logic [5:0] O_ALL    = 6'b111000;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] outs_now();
        return {bus.pc_we, bus.ifid_we, bus.exmem_we,
                bus.ifid_flush, bus.idex_bubble, bus.memwb_bubble};
    endfunction

    function automatic bit operand_not_ready();
        bit load_use, ctl_ex, ctl_mem;
        load_use = bus.ex_memread && bus.ex_regwrite &&
                   ((bus.id_rs_used && bus.ex_rd == bus.id_rs) ||
                    (bus.id_rt_used && bus.ex_rd == bus.id_rt));
        ctl_ex   = bus.id_ctl && bus.ex_regwrite && bus.ex_rd == bus.id_rs;
        ctl_mem  = bus.id_ctl && bus.mem_memread && bus.mem_regwrite &&
                   bus.mem_rd == bus.id_rs;
        return load_use || ctl_ex || ctl_mem;
    endfunction

    function automatic bit mem_blocks_issue();
        return m_waiting ? 1'b0 : bus.dmem_busy;
    endfunction

    function automatic logic [5:0] expected_outs();
        if (!rst) return O_RESET;
        if (m_stopped) return O_HALT;
        if (m_drain_left >= 0) return bus.dmem_busy ? O_FREEZE : O_FETCHX;
        if (m_waiting && !bus.dmem_done) return O_FREEZE;
        if (mem_blocks_issue()) return O_FREEZE;
        if (operand_not_ready()) return O_BUBBLE;
        if (bus.pcsrc) return O_REDIR;
        if (bus.imem_stall || bus.id_halt) return O_FETCHX;
        return O_ALL;
    endfunction

    task automatic model_reset();
        m_stopped    = 1'b0;
        m_waiting    = 1'b0;
        m_drain_left = -1;
        m_stalls     = 0;
    endtask

    task automatic model_edge(input logic [5:0] o);
        if (!o[5] && !m_stopped && m_stalls < 65535) m_stalls++;
        if (m_stopped) begin
        end else if (m_drain_left >= 0) begin
            if (!bus.dmem_busy) begin
                if (m_drain_left == 0) begin
                    m_drain_left = -1;
                    m_stopped    = 1'b1;
                end else begin
                    m_drain_left--;
                end
            end
        end else if (m_waiting && !bus.dmem_done) begin
        end else begin
            if (mem_blocks_issue()) begin
                m_waiting = 1'b1;
            end else begin
                m_waiting = 1'b0;
                if (!operand_not_ready() && !bus.pcsrc && !bus.imem_stall && bus.id_halt)
                    m_drain_left = 2;
            end
        end
    endtask

    task automatic idle();
        bus.id_rs = 3'd0;  bus.id_rt = 3'd0;
        bus.id_rs_used = 1'b0; bus.id_rt_used = 1'b0;
        bus.id_ctl = 1'b0; bus.id_halt = 1'b0;
        bus.ex_rd = 3'd0;  bus.ex_regwrite = 1'b0; bus.ex_memread = 1'b0;
        bus.mem_rd = 3'd0; bus.mem_regwrite = 1'b0; bus.mem_memread = 1'b0;
        bus.pcsrc = 1'b0;  bus.imem_stall = 1'b0;
        bus.dmem_busy = 1'b0; bus.dmem_done = 1'b0;
    endtask

    // One clock: check strobes mid-cycle, then registered outputs after the edge.
    task automatic cyc(input string tag);
        logic [5:0] e;
        @(negedge clk);
        e = expected_outs();
        chk({tag, ".outs"}, {10'd0, outs_now()}, {10'd0, e});
        @(posedge clk);
        model_edge(e);
        #1;
        chk({tag, ".halted"}, {15'd0, bus.halted}, {15'd0, m_stopped});
        chk({tag, ".stall_cnt"}, bus.stall_cnt, 16'(m_stalls));
    endtask

    // Asynchronous reset from mid-cycle; effect must be immediate.
    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        chk({tag, ".rst_halted"}, {15'd0, bus.halted}, 16'd0);
        chk({tag, ".rst_stall"}, bus.stall_cnt, 16'd0);
        chk({tag, ".rst_outs"}, {10'd0, outs_now()}, {10'd0, O_RESET});
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        idle();
        model_reset();
        #2;
        chk("reset.outs", {10'd0, outs_now()}, {10'd0, O_RESET});
        chk("reset.halted", {15'd0, bus.halted}, 16'd0);
        chk("reset.stall", bus.stall_cnt, 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Ordinary load-use: one bubble.
        bus.ex_memread = 1'b1; bus.ex_regwrite = 1'b1; bus.ex_rd = 3'd3;
        bus.id_rs = 3'd3; bus.id_rs_used = 1'b1;
        cyc("lu");
        idle();
        cyc("lu_after");
        chk("lu.stall_total", bus.stall_cnt, 16'd1);

        // Load feeding a register-indirect jump: two bubbles, then redirect.
        bus.ex_memread = 1'b1; bus.ex_regwrite = 1'b1; bus.ex_rd = 3'd7;
        bus.id_rs = 3'd7; bus.id_rs_used = 1'b1; bus.id_ctl = 1'b1;
        cyc("ljr1");
        idle();
        bus.mem_memread = 1'b1; bus.mem_regwrite = 1'b1; bus.mem_rd = 3'd7;
        bus.id_rs = 3'd7; bus.id_rs_used = 1'b1; bus.id_ctl = 1'b1;
        cyc("ljr2");
        idle();
        bus.pcsrc = 1'b1; bus.id_ctl = 1'b1; bus.id_rs = 3'd7;
        @(negedge clk);
        chk("ljr.redir_flush", {15'd0, bus.ifid_flush}, 16'd1);
        chk("ljr.redir_pcwe", {15'd0, bus.pc_we}, 16'd1);
        @(posedge clk);
        model_edge(O_REDIR);
        #1;
        chk("ljr.stall_total", bus.stall_cnt, 16'd3);

        // Data-memory wait: four frozen cycles, release on done.
        idle();
        bus.dmem_busy = 1'b1;
        for (int i = 0; i < 4; i++) cyc("mwait");
        bus.dmem_busy = 1'b0; bus.dmem_done = 1'b1;
        cyc("mwait_done");
        idle();
        chk("mwait.stall_total", bus.stall_cnt, 16'd7);

        // Freeze beats hazard beats redirect.
        bus.dmem_busy = 1'b1; bus.pcsrc = 1'b1;
        bus.ex_regwrite = 1'b1; bus.ex_rd = 3'd2; bus.id_ctl = 1'b1; bus.id_rs = 3'd2;
        cyc("pri_freeze");
        cyc("pri_wait");
        bus.dmem_busy = 1'b0; bus.dmem_done = 1'b1;
        cyc("pri_bubble");
        bus.dmem_done = 1'b0; bus.ex_regwrite = 1'b0;
        cyc("pri_redir");
        idle();
        chk("pri.stall_total", bus.stall_cnt, 16'd10);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            bus.id_rs        = 3'($urandom_range(0, 3));
            bus.id_rt        = 3'($urandom_range(0, 3));
            bus.id_rs_used   = ($urandom_range(0, 1) == 0);
            bus.id_rt_used   = ($urandom_range(0, 1) == 0);
            bus.id_ctl       = ($urandom_range(0, 3) == 0);
            bus.id_halt      = ($urandom_range(0, 40) == 0);
            bus.ex_rd        = 3'($urandom_range(0, 3));
            bus.ex_regwrite  = ($urandom_range(0, 1) == 0);
            bus.ex_memread   = ($urandom_range(0, 2) == 0);
            bus.mem_rd       = 3'($urandom_range(0, 3));
            bus.mem_regwrite = ($urandom_range(0, 1) == 0);
            bus.mem_memread  = ($urandom_range(0, 2) == 0);
            bus.pcsrc        = ($urandom_range(0, 3) == 0);
            bus.imem_stall   = ($urandom_range(0, 5) == 0);
            bus.dmem_busy    = ($urandom_range(0, 5) == 0);
            bus.dmem_done    = ($urandom_range(0, 2) == 0);
            cyc("rand");
            if ((m_stopped && $urandom_range(0, 15) == 0) || $urandom_range(0, 300) == 0)
                do_reset("rand");
        end
        idle();
        do_reset("pre_halt");

        // Halt: three drain cycles, then a held stop.
        bus.id_halt = 1'b1;
        cyc("halt_issue");
        idle();
        for (int i = 0; i < 3; i++) cyc("drain");
        for (int i = 0; i < 12; i++) cyc("halted");
        chk("halt.halted", {15'd0, bus.halted}, 16'd1);
        chk("halt.stall_frozen", bus.stall_cnt, 16'd4);
        @(negedge clk);
        chk("halt.memwb_bubble", {15'd0, bus.memwb_bubble}, 16'd1);
        chk("halt.pc_we", {15'd0, bus.pc_we}, 16'd0);
        @(posedge clk);
        #1;
        do_reset("halt_exit");

        // Saturation of the stall counter.
        bus.imem_stall = 1'b1;
        for (int i = 0; i < 65537; i++) cyc("sat");
        chk("sat.value", bus.stall_cnt, 16'hFFFF);
        idle();

        // Reset in the middle of a drain.
        bus.id_halt = 1'b1;
        cyc("sat_halt");
        idle();
        cyc("sat_drain");
        do_reset("mid_drain");
        cyc("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
